byte_serializer: RTL and testbench
==================================

// Module: byte_serializer
// PURPOSE
//  Upstream feeder of the 8:1 bit-select mux in the TX path.
//  Accepts PSDU bytes over a valid/ready handshake and holds the current byte on outData.
//  Steps outSel through the 8 bit positions, one position per bit-rate strobe.
//  The mux output (outData[outSel]) is the serial bit stream to the symbol/chip stage.
//  Supports back-to-back bytes without a bubble, frame-end marking, underrun detection and per-frame byte count.
// PARAMETERS
//  LSB_FIRST  1  1: outSel counts 0->7 (802.15.4 order); 0: counts 7->0
//  CNT_W      7  width of the per-frame byte counter (127-byte PSDU max)
// PORTS
//  inClk       in   1      single system clock, rising edge
//  inRstN      in   1      asynchronous active-low reset
//  inData      in   8      byte to serialize
//  inValid     in   1      inData/inLast valid
//  inLast      in   1      byte is the final byte of the frame
//  outReady    out  1      block accepts a byte this cycle (combinational)
//  inTick      in   1      bit-rate strobe, 1-cycle pulse; consumes the bit currently presented
//  inFlush     in   1      synchronous abort, returns to IDLE
//  outData     out  8      held byte, to mux inData
//  outSel      out  3      bit index, to mux inSel
//  outBitValid out  1      a valid bit is presented (mux output meaningful)
//  outLast     out  1      presented bit is bit 7 of an inLast byte
//  outUnderrun out  1      1-cycle pulse: byte ended mid-frame with no next byte
//  outByteCnt  out  CNT_W  bytes accepted in the current frame
// BEHAVIOUR
//  Reset (inRstN=0, asynchronous): state=IDLE.
//   outData=0, outSel=FIRST, outBitValid=0, outLast=0, outUnderrun=0, outByteCnt=0.
//   FIRST = 0 if LSB_FIRST, else 7. LASTIDX = 7 if LSB_FIRST, else 0.
//  States:
//   IDLE: no bit presented.
//   SHIFT: byte held, outBitValid=1.
//  outReady = !inFlush && (IDLE || (SHIFT && inTick && outSel==LASTIDX)).
//  Accept = inValid && outReady, taken at the rising edge. On accept:
//   - outData<=inData, outSel<=FIRST, latch last flag, state<=SHIFT.
//   - outByteCnt<=outByteCnt+1, saturating at 2^CNT_W-1.
//  IDLE: inTick ignored. Accept -> SHIFT; first bit is presented from the next cycle.
//  SHIFT, inTick, outSel!=LASTIDX: outSel steps +1 (LSB_FIRST) or -1.
//  SHIFT, inTick, outSel==LASTIDX (byte done):
//   - Accept: reload as above, no bubble cycle.
//   - No accept, latched last=1: -> IDLE, outByteCnt<=0.
//   - No accept, latched last=0: -> IDLE, outUnderrun pulses 1 cycle, outByteCnt held.
//  SHIFT without inTick: all state held; bit stays presented indefinitely.
//  outLast = SHIFT && latched last && outSel==LASTIDX.
//  The next accept after an underrun continues the same frame count.
//  inFlush (highest priority, any state): -> IDLE, outBitValid=0, outSel=FIRST, outByteCnt=0.
//   No accept and no outUnderrun in that cycle. outData is held (don't care).
//  inValid with outReady=0: no accept; upstream holds inData/inLast stable.
//  Asserting inRstN low mid-byte aborts immediately to reset values; no underrun pulse.
//  outSel never leaves 0..7; the counter never wraps.
// TESTING
//  1. LSB_FIRST=1, byte 0xA5 inLast=1, inTick every 4 clk -> outSel 0..7, mux bits 1,0,1,0,0,1,0,1.
//     outLast on bit 7 only, then IDLE, outByteCnt 1->0.
//  2. Bytes 0x12,0x34 (2nd inLast), inValid held -> outReady high only on the bit-7 tick.
//     Byte 0x34 presented on the next cycle; 16 contiguous bits, no gap.
//  3. Byte 0xFF inLast=0, no next byte -> after the 8th tick outUnderrun=1 for exactly 1 cycle.
//     IDLE, outByteCnt stays 1.
//  4. inFlush at bit 3 of 0x5A -> next cycle IDLE, outBitValid=0, outSel=0, outByteCnt=0.
//     inValid in the same cycle is not accepted.
//  5. inRstN low at bit 5 -> all outputs at reset values without waiting for a clock edge.
//  6. LSB_FIRST=0, 0x80 -> outSel 7..0, first mux bit 1.
//     Also: 130 non-last bytes -> outByteCnt saturates at 127.

Source files
------------

// File: rtl/byte_serializer.sv
// byte_serializer: feeds the TX 8:1 bit-select mux. Holds the current PSDU byte on
// outData and walks outSel through the 8 bit positions, one position per inTick
// strobe. outData[outSel] is the serial bit stream to the symbol/chip stage.
// Handshake reload on the final-bit tick gives back-to-back bytes without a bubble.
//
// Ports:
//   inClk       in   1      system clock, rising edge
//   inRstN      in   1      asynchronous active-low reset
//   inData      in   8      byte to serialize
//   inValid     in   1      inData/inLast valid
//   inLast      in   1      byte is the final byte of the frame
//   outReady    out  1      byte accepted this cycle if inValid (combinational)
//   inTick      in   1      bit-rate strobe, consumes the presented bit
//   inFlush     in   1      synchronous abort back to idle
//   outData     out  8      held byte (mux data)
//   outSel      out  3      bit index (mux select)
//   outBitValid out  1      a bit is being presented
//   outLast     out  1      presented bit is the final bit of the frame
//   outUnderrun out  1      1-cycle pulse: mid-frame byte ended with no successor
//   outByteCnt  out  CNT_W  bytes accepted in the current frame (saturating)
module byte_serializer #(
  parameter bit          LSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = 7
) (
  input  logic             inClk,
  input  logic             inRstN,
  input  logic [7:0]       inData,
  input  logic             inValid,
  input  logic             inLast,
  output logic             outReady,
  input  logic             inTick,
  input  logic             inFlush,
  output logic [7:0]       outData,
  output logic [2:0]       outSel,
  output logic             outBitValid,
  output logic             outLast,
  output logic             outUnderrun,
  output logic [CNT_W-1:0] outByteCnt
);

  localparam logic [2:0]       FIRST   = LSB_FIRST ? 3'd0 : 3'd7;
  localparam logic [2:0]       LASTIDX = LSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic [2:0]       sel_q, sel_d;
  logic             last_q, last_d;        // latched inLast of the held byte
  logic             out_last_q, out_last_d;
  logic             under_q, under_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic byte_done_c;
  logic ready_c;
  logic accept_c;

  // Handshake: a new byte can enter when idle or on the tick that consumes the final bit
  always_comb begin
    byte_done_c = (state_q == ST_SHIFT) && inTick && (sel_q == LASTIDX);
    ready_c     = !inFlush && ((state_q == ST_IDLE) || byte_done_c);
    accept_c    = inValid && ready_c;
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    under_d = 1'b0;

    if (inFlush) begin
      state_d = ST_IDLE;
      sel_d   = FIRST;
      last_d  = 1'b0;
      cnt_d   = '0;
    end else if (accept_c) begin
      state_d = ST_SHIFT;
      data_d  = inData;
      sel_d   = FIRST;
      last_d  = inLast;
      cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end else if (byte_done_c) begin
      // Byte finished with nothing to follow: frame end clears the count, otherwise underrun
      state_d = ST_IDLE;
      sel_d   = FIRST;
      last_d  = 1'b0;
      if (last_q) begin
        cnt_d = '0;
      end else begin
        under_d = 1'b1;
      end
    end else if ((state_q == ST_SHIFT) && inTick) begin
      sel_d = LSB_FIRST ? sel_q + 3'd1 : sel_q - 3'd1;
    end

    out_last_d = (state_d == ST_SHIFT) && last_d && (sel_d == LASTIDX);
  end

  // State register
  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      sel_q      <= FIRST;
      last_q     <= 1'b0;
      out_last_q <= 1'b0;
      under_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      out_last_q <= out_last_d;
      under_q    <= under_d;
      cnt_q      <= cnt_d;
    end
  end

  assign outReady    = ready_c;
  assign outData     = data_q;
  assign outSel      = sel_q;
  assign outBitValid = (state_q == ST_SHIFT);
  assign outLast     = out_last_q;
  assign outUnderrun = under_q;
  assign outByteCnt  = cnt_q;

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: both bit orders driven in parallel, checked every cycle
// against a bit-position model, plus directed literal expectations.
module tb_byte_serializer;

  localparam int CNT_W = 7;
  localparam int CMAX  = 127;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_valid = 1'b0, in_last = 1'b0, in_tick = 1'b0, in_flush = 1'b0;

  logic rdy1, bv1, last1, und1;
  logic [7:0] data1;
  logic [2:0] sel1;
  logic [CNT_W-1:0] cnt1;
  logic rdy0, bv0, last0, und0;
  logic [7:0] data0;
  logic [2:0] sel0;
  logic [CNT_W-1:0] cnt0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  byte_serializer #(.LSB_FIRST(1'b1), .CNT_W(CNT_W)) u_lsb (
    .inClk(clk), .inRstN(rst_n), .inData(in_data), .inValid(in_valid), .inLast(in_last),
    .outReady(rdy1), .inTick(in_tick), .inFlush(in_flush), .outData(data1), .outSel(sel1),
    .outBitValid(bv1), .outLast(last1), .outUnderrun(und1), .outByteCnt(cnt1));

  byte_serializer #(.LSB_FIRST(1'b0), .CNT_W(CNT_W)) u_msb (
    .inClk(clk), .inRstN(rst_n), .inData(in_data), .inValid(in_valid), .inLast(in_last),
    .outReady(rdy0), .inTick(in_tick), .inFlush(in_flush), .outData(data0), .outSel(sel0),
    .outBitValid(bv0), .outLast(last0), .outUnderrun(und0), .outByteCnt(cnt0));

  logic ser1, ser0;
  assign ser1 = data1[sel1];
  assign ser0 = data0[sel0];

  function automatic void chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
  endfunction

  // Model: k = number of bits of the held byte already consumed
  logic       m_busy = 1'b0, m_last = 1'b0, m_under = 1'b0, m_ready;
  logic [7:0] m_byte = 8'h00;
  int         m_k = 0, m_cnt = 0;

  task automatic model_compare();
    chk("data_lsb", int'(data1), int'(m_byte));
    chk("data_msb", int'(data0), int'(m_byte));
    chk("sel_lsb", int'(sel1), m_k);
    chk("sel_msb", int'(sel0), 7 - m_k);
    chk("bv_lsb", int'(bv1), int'(m_busy));
    chk("bv_msb", int'(bv0), int'(m_busy));
    chk("last_lsb", int'(last1), int'(m_busy && m_last && m_k == 7));
    chk("last_msb", int'(last0), int'(m_busy && m_last && m_k == 7));
    chk("under_lsb", int'(und1), int'(m_under));
    chk("under_msb", int'(und0), int'(m_under));
    chk("cnt_lsb", int'(cnt1), m_cnt);
    chk("cnt_msb", int'(cnt0), m_cnt);
    if (m_busy) begin
      chk("ser_lsb", int'(ser1), int'(m_byte[m_k]));
      chk("ser_msb", int'(ser0), int'(m_byte[7 - m_k]));
    end
  endtask

  // Compare process: ready checked on pre-edge state, registered outputs 1 time unit after
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 1'b0; m_last = 1'b0; m_under = 1'b0; m_byte = 8'h00; m_k = 0; m_cnt = 0;
      end else begin
        m_ready = !in_flush && (!m_busy || (in_tick && m_k == 7));
        chk("ready_lsb", int'(rdy1), int'(m_ready));
        chk("ready_msb", int'(rdy0), int'(m_ready));
        m_under = 1'b0;
        if (in_flush) begin
          m_busy = 1'b0; m_k = 0; m_cnt = 0; m_last = 1'b0;
        end else if (in_valid && m_ready) begin
          m_byte = in_data; m_k = 0; m_last = in_last; m_busy = 1'b1;
          m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        end else if (m_busy && in_tick) begin
          if (m_k == 7) begin
            m_busy = 1'b0; m_k = 0;
            if (m_last) m_cnt = 0;
            else m_under = 1'b1;
            m_last = 1'b0;
          end else begin
            m_k++;
          end
        end
      end
      #1;
      model_compare();
    end
  end

  // One clock of stimulus; acc reports whether the byte was taken at that edge
  task automatic cyc(input logic v, input logic [7:0] d, input logic l, input logic t,
                     input logic f, output logic acc);
    in_valid = v; in_data = d; in_last = l; in_tick = t; in_flush = f;
    @(posedge clk);
    acc = v && rdy1;
    #2;
  endtask

  logic a;
  int   n, nb, nu;
  logic [7:0] bits;
  logic [7:0] exp_bits;
  logic       v;
  logic [7:0] d;
  logic       l;

  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("rst_bv", int'(bv1), 0);
    chk("rst_sel_msb", int'(sel0), 7);

    // 0xA5 as a one-byte frame, tick every 4 clocks
    cyc(1, 8'hA5, 1, 0, 0, a);
    chk("t1_acc", int'(a), 1);
    for (int i = 0; i < 8; i++) begin
      repeat (3) cyc(0, 8'h00, 0, 0, 0, a);
      bits[i] = ser1;
      chk("t1_lastflag", int'(last1), (i == 7) ? 1 : 0);
      chk("t1_cnt", int'(cnt1), 1);
      cyc(0, 8'h00, 0, 1, 0, a);
    end
    exp_bits = 8'b1010_0101;  // bits in presentation order: 1,0,1,0,0,1,0,1 (index 0 first)
    for (int i = 0; i < 8; i++) chk("t1_bit", int'(bits[i]), int'(exp_bits[7 - i]));
    chk("t1_idle", int'(bv1), 0);
    chk("t1_cnt_clr", int'(cnt1), 0);

    // back-to-back 0x12,0x34 with inValid held
    cyc(1, 8'h12, 0, 0, 0, a);
    n = 0; nb = 0; a = 1'b0;
    while (!a && n < 20) begin
      if (bv1) nb++;
      cyc(1, 8'h34, 1, 1, 0, a);
      n++;
    end
    chk("t2_wait", n, 8);
    chk("t2_data", int'(data1), 8'h34);
    chk("t2_sel", int'(sel1), 0);
    repeat (8) begin
      if (bv1) nb++;
      cyc(0, 8'h00, 0, 1, 0, a);
    end
    chk("t2_contig", nb, 16);
    chk("t2_idle", int'(bv1), 0);

    // underrun after a non-last byte
    cyc(1, 8'hFF, 0, 0, 0, a);
    nu = 0;
    repeat (8) begin
      cyc(0, 8'h00, 0, 1, 0, a);
      if (und1) nu++;
    end
    repeat (4) begin
      cyc(0, 8'h00, 0, 0, 0, a);
      if (und1) nu++;
    end
    chk("t3_pulses", nu, 1);
    chk("t3_cnt", int'(cnt1), 1);
    cyc(1, 8'h01, 1, 0, 0, a);
    chk("t3_cnt_cont", int'(cnt1), 2);
    repeat (8) cyc(0, 8'h00, 0, 1, 0, a);
    chk("t3_cnt_end", int'(cnt1), 0);

    // flush at bit 3, with a competing inValid
    cyc(1, 8'h5A, 0, 0, 0, a);
    repeat (3) cyc(0, 8'h00, 0, 1, 0, a);
    chk("t4_sel3", int'(sel1), 3);
    cyc(1, 8'h77, 1, 0, 1, a);
    chk("t4_noacc", int'(a), 0);
    chk("t4_bv", int'(bv1), 0);
    chk("t4_sel", int'(sel1), 0);
    chk("t4_cnt", int'(cnt1), 0);

    // async reset at bit 5
    cyc(1, 8'hC3, 1, 0, 0, a);
    repeat (5) cyc(0, 8'h00, 0, 1, 0, a);
    chk("t5_sel5", int'(sel1), 5);
    #4 rst_n = 1'b0;
    #1;
    chk("t5_bv", int'(bv1), 0);
    chk("t5_sel", int'(sel1), 0);
    chk("t5_data", int'(data1), 0);
    chk("t5_cnt", int'(cnt1), 0);
    chk("t5_under", int'(und1), 0);
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;

    // MSB-first order on 0x80
    cyc(1, 8'h80, 1, 0, 0, a);
    chk("t6_msb_sel", int'(sel0), 7);
    chk("t6_msb_bit", int'(ser0), 1);
    chk("t6_lsb_bit", int'(ser1), 0);
    repeat (8) cyc(0, 8'h00, 0, 1, 0, a);

    // 130 non-last bytes back to back: counter saturates
    cyc(1, 8'h00, 0, 0, 0, a);
    for (int i = 1; i < 130; i++) begin
      n = 0; a = 1'b0;
      while (!a && n < 20) begin
        cyc(1, 8'(i), 0, 1, 0, a);
        n++;
      end
      if (!a) chk("t6_acc_timeout", 0, 1);
    end
    chk("t6_sat", int'(cnt1), 127);
    chk("t6_sat_msb", int'(cnt0), 127);
    cyc(0, 8'h00, 0, 0, 1, a);

    // randomized traffic
    v = 1'b0; d = 8'h00; l = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (!v && ($urandom % 3 == 0)) begin
        v = 1'b1; d = 8'($urandom); l = ($urandom % 4 == 0);
      end
      cyc(v, d, l, 1'($urandom % 2), ($urandom % 97 == 0), a);
      if (a) v = 1'b0;
    end
    cyc(0, 8'h00, 0, 0, 0, a);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
